// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card accept, PIN check with retry limit, operation menu,
// saturating balance arithmetic, write-back and eject toward the card database.
module atm_session_ctrl #(
    parameter int CARD_W      = 3,
    parameter int BAL_W       = 20,
    parameter int USERS_NUM   = 7,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              card_in,
    input  logic [CARD_W-1:0] card_number,
    input  logic              pin_valid,
    input  logic              wrong_psw,
    input  logic [BAL_W-1:0]  balance_in,
    input  logic              op_valid,
    input  logic [1:0]        op_code,
    input  logic [BAL_W-1:0]  amount,
    output logic [CARD_W-1:0] card_sel,
    output logic              card_out,
    output logic              op_done,
    output logic [BAL_W-1:0]  updated_balance,
    output logic [BAL_W-1:0]  balance_disp,
    output logic              pin_err,
    output logic              pin_locked,
    output logic              insufficient,
    output logic              overflow,
    output logic              timeout
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [CARD_W-1:0] SENTINEL = CARD_W'(USERS_NUM);
    localparam logic [TRY_W-1:0]  LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, PIN_WAIT, PIN_CHECK, MENU, EXEC, EJECT} state_t;
    typedef enum logic [1:0] {OP_BAL = 2'b00, OP_WD = 2'b01, OP_DEP = 2'b10, OP_EXIT = 2'b11} op_t;

    state_t            state, state_nx;
    op_t               op_q, op_nx;
    logic [BAL_W-1:0]  bal, bal_nx, amt_q, amt_nx, upd_nx, disp_nx;
    logic [BAL_W:0]    dep_sum;
    logic [CARD_W-1:0] sel_nx;
    logic [TRY_W-1:0]  tries, tries_nx;
    logic [TMR_W-1:0]  timer, timer_nx;
    logic              card_out_nx, eject;
    logic              op_done_nx, pin_err_nx, pin_locked_nx;
    logic              insufficient_nx, overflow_nx, timeout_nx;

    assign dep_sum = {1'b0, bal} + {1'b0, amt_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            op_q            <= OP_BAL;
            bal             <= '0;
            amt_q           <= '0;
            tries           <= '0;
            timer           <= '0;
            card_sel        <= SENTINEL;
            card_out        <= 1'b1;
            updated_balance <= '0;
            balance_disp    <= '0;
            op_done         <= 1'b0;
            pin_err         <= 1'b0;
            pin_locked      <= 1'b0;
            insufficient    <= 1'b0;
            overflow        <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            state           <= state_nx;
            op_q            <= op_nx;
            bal             <= bal_nx;
            amt_q           <= amt_nx;
            tries           <= tries_nx;
            timer           <= timer_nx;
            card_sel        <= sel_nx;
            card_out        <= card_out_nx;
            updated_balance <= upd_nx;
            balance_disp    <= disp_nx;
            op_done         <= op_done_nx;
            pin_err         <= pin_err_nx;
            pin_locked      <= pin_locked_nx;
            insufficient    <= insufficient_nx;
            overflow        <= overflow_nx;
            timeout         <= timeout_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        op_nx           = op_q;
        bal_nx          = bal;
        amt_nx          = amt_q;
        tries_nx        = tries;
        timer_nx        = '0;   // only an uneventful wait cycle keeps counting
        sel_nx          = card_sel;
        card_out_nx     = card_out;
        upd_nx          = updated_balance;
        disp_nx         = balance_disp;
        op_done_nx      = 1'b0;
        pin_err_nx      = 1'b0;
        pin_locked_nx   = 1'b0;
        insufficient_nx = 1'b0;
        overflow_nx     = 1'b0;
        timeout_nx      = 1'b0;
        eject           = 1'b0;

        case (state)
            IDLE: begin
                if (card_in) begin
                    if (card_number < SENTINEL) begin
                        sel_nx      = card_number;
                        card_out_nx = 1'b0;
                        tries_nx    = '0;
                        state_nx    = PIN_WAIT;
                    end else begin
                        state_nx = EJECT;
                    end
                end
            end
            PIN_WAIT: begin
                if (!card_in) begin
                    eject = 1'b1;
                end else if (pin_valid) begin
                    state_nx = PIN_CHECK;
                end else if (timer == TMR_LAST) begin
                    timeout_nx = 1'b1;
                    eject      = 1'b1;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            PIN_CHECK: begin
                if (!card_in) begin
                    eject = 1'b1;
                end else if (!wrong_psw) begin
                    bal_nx   = balance_in;
                    upd_nx   = balance_in;
                    disp_nx  = balance_in;
                    state_nx = MENU;
                end else if (tries == LAST_TRY) begin
                    pin_locked_nx = 1'b1;
                    eject         = 1'b1;
                end else begin
                    tries_nx   = tries + 1'b1;
                    pin_err_nx = 1'b1;
                    state_nx   = PIN_WAIT;
                end
            end
            MENU: begin
                if (!card_in) begin
                    eject = 1'b1;
                end else if (op_valid) begin
                    case (op_t'(op_code))
                        OP_BAL:  disp_nx = bal;
                        OP_EXIT: eject = 1'b1;
                        default: begin
                            op_nx    = op_t'(op_code);
                            amt_nx   = amount;
                            state_nx = EXEC;
                        end
                    endcase
                end else if (timer == TMR_LAST) begin
                    timeout_nx = 1'b1;
                    eject      = 1'b1;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            EXEC: begin
                if (!card_in) begin
                    eject = 1'b1;
                end else begin
                    state_nx = MENU;
                    if (op_q == OP_DEP) begin
                        op_done_nx  = 1'b1;
                        overflow_nx = dep_sum[BAL_W];
                        bal_nx      = dep_sum[BAL_W] ? '1 : dep_sum[BAL_W-1:0];
                    end else if (amt_q <= bal) begin
                        op_done_nx = 1'b1;
                        bal_nx     = bal - amt_q;
                    end else begin
                        insufficient_nx = 1'b1;
                    end
                    upd_nx  = bal_nx;
                    disp_nx = bal_nx;
                end
            end
            EJECT: begin
                if (!card_in) begin
                    sel_nx   = SENTINEL;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // card_sel stays valid on the way into EJECT so the database writes the final balance
        if (eject) begin
            state_nx    = EJECT;
            card_out_nx = 1'b1;
        end
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Self-checking bench for atm_session_ctrl: directed corner cases plus randomized sessions
// checked against a transaction-level model of the account balances.
module tb_atm_session_ctrl;

    localparam int CARD_W = 3;
    localparam int BAL_W  = 20;
    localparam int USERS  = 7;
    localparam int TRIES  = 3;
    localparam int TMO    = 20;
    localparam logic [BAL_W-1:0] BMAX = '1;

    localparam logic [5:0] P_NONE = 6'b000000;
    localparam logic [5:0] P_DONE = 6'b100000;
    localparam logic [5:0] P_ERR  = 6'b010000;
    localparam logic [5:0] P_LOCK = 6'b001000;
    localparam logic [5:0] P_INS  = 6'b000100;
    localparam logic [5:0] P_OVF  = 6'b000010;
    localparam logic [5:0] P_TMO  = 6'b000001;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              card_in = 1'b0;
    logic [CARD_W-1:0] card_number = '0;
    logic              pin_valid = 1'b0;
    logic              wrong_psw = 1'b0;
    logic [BAL_W-1:0]  balance_in = '0;
    logic              op_valid = 1'b0;
    logic [1:0]        op_code = '0;
    logic [BAL_W-1:0]  amount = '0;
    logic [CARD_W-1:0] card_sel;
    logic              card_out, op_done, pin_err, pin_locked, insufficient, overflow, timeout;
    logic [BAL_W-1:0]  updated_balance, balance_disp;

    atm_session_ctrl #(
        .CARD_W(CARD_W), .BAL_W(BAL_W), .USERS_NUM(USERS), .MAX_TRIES(TRIES), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .card_in(card_in), .card_number(card_number),
        .pin_valid(pin_valid), .wrong_psw(wrong_psw), .balance_in(balance_in),
        .op_valid(op_valid), .op_code(op_code), .amount(amount),
        .card_sel(card_sel), .card_out(card_out), .op_done(op_done),
        .updated_balance(updated_balance), .balance_disp(balance_disp),
        .pin_err(pin_err), .pin_locked(pin_locked), .insufficient(insufficient),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Account store: the bench's own record of committed balances, served back as balance_in.
    logic [BAL_W-1:0] store [0:7];
    always @(posedge clk) balance_in <= store[card_sel];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_cmp = 0, n_bad = 0;
    int unsigned quiet_since = 0;
    int          cur = 0;
    int          m_tries = 0;
    logic [BAL_W-1:0] m_bal = '0, m_upd = '0, m_disp = '0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] pulses();
        return {op_done, pin_err, pin_locked, insufficient, overflow, timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input int n);
        cur = n; m_tries = 0;
        card_number = CARD_W'(n); card_in = 1'b1;
        tick();
        quiet_since = cyc;
        if (n < USERS) begin
            check("insert_sel", card_sel, n);
            check("insert_out", card_out, 0);
        end else begin
            check("bad_card_sel", card_sel, USERS);
            check("bad_card_out", card_out, 1);
            tick();
            check("bad_card_hold", card_sel, USERS);
        end
    endtask

    task automatic pull(input bit active);
        card_in = 1'b0;
        tick();
        if (active) begin
            check("pull_out", card_out, 1);
            check("pull_sel", card_sel, cur);
            check("pull_pulses", pulses(), P_NONE);
            tick();
        end
        check("idle_sel", card_sel, USERS);
        check("idle_out", card_out, 1);
        check("idle_pulses", pulses(), P_NONE);
    endtask

    task automatic pin(input bit wrong, output bit locked);
        locked = 1'b0;
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        check("pin_check_pulses", pulses(), P_NONE);
        wrong_psw = wrong;
        tick();
        wrong_psw = 1'b0;
        quiet_since = cyc;
        if (!wrong) begin
            m_bal = store[cur]; m_upd = m_bal; m_disp = m_bal;
            check("pin_ok_disp", balance_disp, m_disp);
            check("pin_ok_upd", updated_balance, m_upd);
            check("pin_ok_pulses", pulses(), P_NONE);
        end else if (m_tries + 1 < TRIES) begin
            m_tries++;
            check("pin_err_pulses", pulses(), P_ERR);
            check("pin_err_out", card_out, 0);
        end else begin
            locked = 1'b1;
            check("pin_lock_pulses", pulses(), P_LOCK);
            check("pin_lock_out", card_out, 1);
            check("pin_lock_sel", card_sel, cur);
        end
        tick();
        check("pin_pulse_width", pulses(), P_NONE);
    endtask

    task automatic op(input int code, input logic [BAL_W-1:0] amt);
        longint   sum;
        logic [5:0] exp_p;
        op_valid = 1'b1; op_code = 2'(code); amount = amt;
        tick();
        op_valid = 1'b0; amount = BAL_W'($urandom);
        if (code == 0) begin
            quiet_since = cyc;
            check("op_bal_disp", balance_disp, m_bal);
            check("op_bal_pulses", pulses(), P_NONE);
        end else if (code == 3) begin
            check("op_exit_out", card_out, 1);
            check("op_exit_sel", card_sel, cur);
            check("op_exit_pulses", pulses(), P_NONE);
        end else begin
            check("op_exec_pulses", pulses(), P_NONE);
            tick();
            quiet_since = cyc;
            if (code == 1) begin
                if (amt <= m_bal) begin
                    m_bal = m_bal - amt; exp_p = P_DONE;
                end else begin
                    exp_p = P_INS;
                end
            end else begin
                sum = longint'(m_bal) + longint'(amt);
                if (sum > longint'(BMAX)) begin
                    m_bal = BMAX; exp_p = P_DONE | P_OVF;
                end else begin
                    m_bal = BAL_W'(sum); exp_p = P_DONE;
                end
            end
            if (exp_p[5]) begin
                m_upd = m_bal; m_disp = m_bal; store[cur] = m_bal;
            end
            check("op_result_pulses", pulses(), exp_p);
            check("op_result_upd", updated_balance, m_upd);
            check("op_result_disp", balance_disp, m_disp);
            tick();
            check("op_pulse_width", pulses(), P_NONE);
        end
    endtask

    task automatic wait_timeout();
        bit seen = 1'b0;
        for (int i = 0; i < TMO + 5; i++) begin
            tick();
            if (timeout) begin
                seen = 1'b1;
                break;
            end
        end
        check("timeout_seen", seen, 1);
        if (seen) begin
            check("timeout_latency", cyc - quiet_since, TMO);
            check("timeout_out", card_out, 1);
            check("timeout_sel", card_sel, cur);
        end
    endtask

    // Quiet menu cycles with ignored stray keypad/op-bus activity; op_valid stays low.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            pin_valid = ($urandom_range(0, 3) == 0);
            wrong_psw = 1'($urandom);
            amount    = BAL_W'($urandom);
            op_code   = 2'($urandom);
            tick();
            check("gap_pulses", pulses(), P_NONE);
        end
        pin_valid = 1'b0; wrong_psw = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit locked;
        int code;
        logic [BAL_W-1:0] amt;

        for (int i = 0; i < 8; i++) store[i] = BAL_W'($urandom);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check("reset_sel", card_sel, USERS);
        check("reset_out", card_out, 1);
        check("reset_upd", updated_balance, 0);
        check("reset_disp", balance_disp, 0);
        check("reset_pulses", pulses(), P_NONE);

        // Withdraw sequence on card 2
        store[2] = 500;
        insert(2);
        pin(1'b0, locked);
        op(1, 200);
        check("wd200_upd", updated_balance, 300);
        op(1, 400);
        check("wd400_upd", updated_balance, 300);
        op(1, 0);
        op(0, 0);
        op(3, 0);
        pull(1'b0);

        // Deposit saturation, then menu inactivity timeout
        store[3] = BMAX - 9;
        insert(3);
        pin(1'b0, locked);
        op(2, 50);
        check("dep_sat_upd", updated_balance, BMAX);
        wait_timeout();
        pull(1'b0);

        // Lock-out after three wrong PINs; card stays selected until removed
        insert(4);
        for (int i = 0; i < TRIES; i++) pin(1'b1, locked);
        check("lock_after_max", locked, 1);
        tick();
        check("lock_hold_sel", card_sel, 4);
        pull(1'b0);

        // Out-of-range card
        insert(7);
        pull(1'b0);

        // PIN entry timeout
        insert(0);
        wait_timeout();
        pull(1'b0);

        // Asynchronous reset during EXEC aborts without commit
        insert(1);
        pin(1'b0, locked);
        op_valid = 1'b1; op_code = 2'b01; amount = 1;
        tick();
        op_valid = 1'b0;
        rst = 1'b0; card_in = 1'b0;
        #1;
        check("rst_exec_sel", card_sel, USERS);
        check("rst_exec_out", card_out, 1);
        check("rst_exec_upd", updated_balance, 0);
        check("rst_exec_pulses", pulses(), P_NONE);
        @(negedge clk);
        rst = 1'b1;
        m_upd = '0; m_disp = '0;
        tick();
        check("rst_exec_after", pulses(), P_NONE);
        check("rst_exec_idle_sel", card_sel, USERS);

        // Card pulled together with op_valid: op dropped
        insert(5);
        pin(1'b0, locked);
        card_in = 1'b0; op_valid = 1'b1; op_code = 2'b01; amount = 0;
        tick();
        op_valid = 1'b0;
        check("pull_op_pulses", pulses(), P_NONE);
        check("pull_op_out", card_out, 1);
        check("pull_op_sel", card_sel, 5);
        tick();
        check("pull_op_idle", card_sel, USERS);
        check("pull_op_after", pulses(), P_NONE);

        // Card pulled while EXEC is pending
        insert(6);
        pin(1'b0, locked);
        op_valid = 1'b1; op_code = 2'b10; amount = 5;
        tick();
        op_valid = 1'b0;
        pull(1'b1);

        // Randomized sessions
        for (int s = 0; s < 40; s++) begin
            insert($urandom_range(0, 7));
            if (cur == 7) begin
                pull(1'b0);
                continue;
            end
            locked = 1'b0;
            for (int w = $urandom_range(0, 3); w > 0 && !locked; w--) pin(1'b1, locked);
            if (locked) begin
                pull(1'b0);
                continue;
            end
            pin(1'b0, locked);
            for (int k = $urandom_range(0, 6); k > 0; k--) begin
                gap($urandom_range(0, TMO - 4));
                code = $urandom_range(0, 2);
                if (code == 1)
                    amt = ($urandom_range(0, 1) == 0 || m_bal == BMAX)
                        ? BAL_W'($urandom_range(0, int'(m_bal)))
                        : m_bal + BAL_W'($urandom_range(1, 100));
                else
                    amt = ($urandom_range(0, 1) == 0) ? BAL_W'($urandom_range(0, 1000)) : BAL_W'($urandom);
                op(code, amt);
            end
            case ($urandom_range(0, 2))
                0: begin op(3, 0); pull(1'b0); end
                1: pull(1'b1);
                default: begin wait_timeout(); pull(1'b0); end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
